// File: rtl/hist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hist_pkg
// Description : Shared types and constants for the histogram RAM scheduler:
//               FSM state encoding, bin/log geometry and the sample-to-bin
//               mapping function.
//               Optional feature macro: HIST_VALUE_LOG_EN (adds ST_LOG_WR).
// Revision    : 1.0 - initial release
// ============================================================================
package hist_pkg;

  localparam int NUM_BINS   = 8;     // fixed 32-wide binning needs exactly 8
  localparam int CNT_STRIDE = 4;     // counter word address = bin*CNT_STRIDE
  localparam int LOG_BASE   = 'h20;  // start of the per-bin sample-value log
  localparam int LOG_DEPTH  = 16;    // log entries kept per bin
  localparam int BIN_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLR      = 3'd1,
    ST_RMW_RD   = 3'd2,
    ST_RMW_WAIT = 3'd3,
    ST_RMW_WR   = 3'd4,
`ifdef HIST_VALUE_LOG_EN
    ST_LOG_WR   = 3'd5,
`endif
    ST_HRD      = 3'd6,
    ST_HRD_WAIT = 3'd7
  } state_e;

  // 0..32 -> 0, 33..64 -> 1, ..., 225..255 -> 7
  function automatic logic [BIN_W-1:0] bin_of(input logic [7:0] v);
    logic [7:0] v_m1;
    v_m1 = v - 8'd1;
    return (v == 8'd0) ? '0 : v_m1[7:5];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hist_bin_map.sv
`default_nettype none
// ============================================================================
// Module      : hist_bin_map
// Description : Combinational LFSR sample value -> histogram bin index.
//               Optional feature macro: none.
// Revision    : 1.0 - initial release
// ============================================================================
module hist_bin_map
  import hist_pkg::*;
(
  input  logic [7:0]       i_value,
  output logic [BIN_W-1:0] o_bin
);

  // map the raw sample onto its 32-wide bin
  always_comb begin
    o_bin = bin_of(i_value);
  end

endmodule
`default_nettype wire

// File: rtl/hist_ram_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hist_ram_scheduler
// Description : Owns the single-port histogram RAM and time-shares it between
//               bin-counter read-modify-writes from the sample stream, host
//               readback and a full-RAM clear sweep. Host and sample requests
//               are round-robin arbitrated; clear has top priority but never
//               interrupts an access already in flight.
//               Optional feature macro: HIST_VALUE_LOG_EN (per-bin log of the
//               first LOG_DEPTH sample values).
// Revision    : 1.0 - initial release
// ============================================================================
module hist_ram_scheduler
  import hist_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      clear_req,
  output logic                      clear_busy,
  input  logic                      s_sample_valid,
  input  logic [7:0]                s_sample_data,
  output logic                      s_sample_ready,
  input  logic                      host_rd_req,
  input  logic [RAM_ADDR_WIDTH-1:0] host_rd_addr,
  output logic                      host_rd_ack,
  output logic [RAM_DATA_WIDTH-1:0] host_rd_data,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] ram_wdata,
  input  logic [RAM_DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [RAM_ADDR_WIDTH-1:0] C_ADDR_LAST = '1;
  localparam logic [RAM_DATA_WIDTH-1:0] C_CNT_MAX   = '1;

  state_e                    state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;        // sweep / host address
  logic [BIN_W-1:0]          bin_q, bin_d;          // bin of accepted sample
  logic [RAM_DATA_WIDTH-1:0] old_q, old_d;          // counter value read back
  logic                      clr_pend_q, clr_pend_d;
  logic                      clear_busy_q, clear_busy_d;
  logic                      last_host_q, last_host_d;  // 0: sample won last
  logic [RAM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
`ifdef HIST_VALUE_LOG_EN
  logic [7:0]                sample_q, sample_d;
  logic [RAM_ADDR_WIDTH-1:0] w_log_addr;
`endif

  logic [BIN_W-1:0]          w_bin;
  logic [RAM_ADDR_WIDTH-1:0] w_cnt_addr;
  logic                      w_idle_free;
  logic                      w_grant_sample;
  logic                      w_grant_host;

  hist_bin_map u_bin_map (
    .i_value (s_sample_data),
    .o_bin   (w_bin)
  );

  assign w_cnt_addr = RAM_ADDR_WIDTH'(32'(bin_q) * CNT_STRIDE);
`ifdef HIST_VALUE_LOG_EN
  assign w_log_addr = RAM_ADDR_WIDTH'(LOG_BASE + 32'(bin_q) * LOG_DEPTH + 32'(old_q));
`endif

  // Round-robin: with both requesters present the one not served last wins.
  assign w_idle_free    = (state_q == ST_IDLE) && !clr_pend_q;
  assign w_grant_sample = w_idle_free && s_sample_valid && (!host_rd_req || last_host_q);
  assign w_grant_host   = w_idle_free && host_rd_req && (!s_sample_valid || !last_host_q);

  // state register with synchronous reset back to IDLE
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      bin_q        <= '0;
      old_q        <= '0;
      clr_pend_q   <= 1'b0;
      clear_busy_q <= 1'b0;
      last_host_q  <= 1'b0;
      rd_data_q    <= '0;
`ifdef HIST_VALUE_LOG_EN
      sample_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bin_q        <= bin_d;
      old_q        <= old_d;
      clr_pend_q   <= clr_pend_d;
      clear_busy_q <= clear_busy_d;
      last_host_q  <= last_host_d;
      rd_data_q    <= rd_data_d;
`ifdef HIST_VALUE_LOG_EN
      sample_q     <= sample_d;
`endif
    end
  end

  // next-state, arbitration results and clear bookkeeping
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    bin_d        = bin_q;
    old_d        = old_q;
    clr_pend_d   = clr_pend_q;
    clear_busy_d = clear_busy_q;
    last_host_d  = last_host_q;
    rd_data_d    = rd_data_q;
`ifdef HIST_VALUE_LOG_EN
    sample_d     = sample_q;
`endif

    // a clear request is remembered until the FSM is free to sweep
    if (clear_req) begin
      clr_pend_d   = 1'b1;
      clear_busy_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          state_d    = ST_CLR;
          addr_d     = '0;
          clr_pend_d = 1'b0;
        end else if (w_grant_sample) begin
          state_d     = ST_RMW_RD;
          bin_d       = w_bin;
          last_host_d = 1'b0;
`ifdef HIST_VALUE_LOG_EN
          sample_d    = s_sample_data;
`endif
        end else if (w_grant_host) begin
          state_d     = ST_HRD;
          addr_d      = host_rd_addr;
          last_host_d = 1'b1;
        end
      end
      ST_CLR: begin
        // a new request inside the sweep simply restarts it
        clr_pend_d = 1'b0;
        if (clear_req) begin
          addr_d = '0;
        end else if (addr_q == C_ADDR_LAST) begin
          state_d      = ST_IDLE;
          clear_busy_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_RMW_RD: state_d = ST_RMW_WAIT;
      ST_RMW_WAIT: begin
        old_d   = ram_rdata;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        state_d = ST_IDLE;
`ifdef HIST_VALUE_LOG_EN
        if (old_q < RAM_DATA_WIDTH'(LOG_DEPTH)) state_d = ST_LOG_WR;
`endif
      end
`ifdef HIST_VALUE_LOG_EN
      ST_LOG_WR: state_d = ST_IDLE;
`endif
      ST_HRD: state_d = ST_HRD_WAIT;
      ST_HRD_WAIT: begin
        rd_data_d = ram_rdata;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM strobes and handshake outputs decoded from the current state
  always_comb begin
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = '0;
    ram_wdata      = '0;
    s_sample_ready = 1'b0;
    host_rd_ack    = 1'b0;
    host_rd_data   = rd_data_q;
    clear_busy     = clear_busy_q;

    unique case (state_q)
      ST_IDLE: s_sample_ready = w_grant_sample;
      ST_CLR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = addr_q;
      end
      ST_RMW_RD: begin
        ram_en   = 1'b1;
        ram_addr = w_cnt_addr;
      end
      ST_RMW_WR: begin
        // counters saturate rather than wrap
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = w_cnt_addr;
        ram_wdata = (old_q == C_CNT_MAX) ? old_q : old_q + 1'b1;
      end
`ifdef HIST_VALUE_LOG_EN
      ST_LOG_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = w_log_addr;
        ram_wdata = RAM_DATA_WIDTH'(sample_q);
      end
`endif
      ST_HRD: begin
        ram_en   = 1'b1;
        ram_addr = addr_q;
      end
      ST_HRD_WAIT: begin
        host_rd_ack  = 1'b1;
        host_rd_data = ram_rdata;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_hist_ram_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hist_ram_scheduler
// Description : Self-checking bench for hist_ram_scheduler with a behavioural
//               RAM and a histogram reference model.
//               Optional feature macro: HIST_VALUE_LOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hist_ram_scheduler;

  localparam int AW = 8;
  localparam int DW = 32;
`ifdef HIST_VALUE_LOG_EN
  localparam int RMW_MAX = 4;
`else
  localparam int RMW_MAX = 3;
`endif

  logic          aclk = 1'b0;
  logic          areset, clear_req, clear_busy;
  logic          s_sample_valid, s_sample_ready;
  logic [7:0]    s_sample_data;
  logic          host_rd_req, host_rd_ack;
  logic [AW-1:0] host_rd_addr;
  logic [DW-1:0] host_rd_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 aclk = ~aclk;

  hist_ram_scheduler #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .clear_req      (clear_req),
    .clear_busy     (clear_busy),
    .s_sample_valid (s_sample_valid),
    .s_sample_data  (s_sample_data),
    .s_sample_ready (s_sample_ready),
    .host_rd_req    (host_rd_req),
    .host_rd_addr   (host_rd_addr),
    .host_rd_ack    (host_rd_ack),
    .host_rd_data   (host_rd_data),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata)
  );

  // single-port RAM with a backdoor write port for preloading
  logic [DW-1:0] mem [256];
  logic          bd_we;
  logic [7:0]    bd_addr;
  logic [DW-1:0] bd_data;

  always @(posedge aclk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_mem [256];
  logic          acc_now, ack_now;
  logic [DW-1:0] ack_data;
  wr_t           wr_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // reference: 33-value-wide bin 0, then 32-wide bins
  function automatic int ref_bin(input int v);
    return (v <= 32) ? 0 : (v - 1) / 32;
  endfunction

  task automatic model_accept(input logic [7:0] v);
    int b, a;
    logic [31:0] old;
    b   = ref_bin(int'(v));
    a   = b * 4;
    old = exp_mem[a];
`ifdef HIST_VALUE_LOG_EN
    if (old < 32'd16) exp_mem[32 + b * 16 + int'(old)] = 32'(v);
`endif
    exp_mem[a] = (old == 32'hFFFF_FFFF) ? old : old + 32'd1;
  endtask

  task automatic observe();
    acc_now = 1'b0;
    ack_now = 1'b0;
    if (s_sample_valid && s_sample_ready) begin
      model_accept(s_sample_data);
      acc_now = 1'b1;
    end
    if (clear_req && !areset)
      for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    if (ram_en && ram_we) wr_q.push_back('{a: ram_addr, d: ram_wdata});
    if (host_rd_ack) begin
      ack_now  = 1'b1;
      ack_data = host_rd_data;
      check_eq("host_rd_vs_model", host_rd_data, exp_mem[host_rd_addr]);
    end
  endtask

  // inputs change at the falling edge; outputs are looked at 1ns later
  task automatic tick();
    #1;
    observe();
    @(negedge aclk);
  endtask

  task automatic host_read(input logic [7:0] addr, output logic [31:0] data);
    logic got;
    got          = 1'b0;
    data         = '0;
    host_rd_req  = 1'b1;
    host_rd_addr = addr;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (ack_now) begin
        got  = 1'b1;
        data = ack_data;
      end
    end
    host_rd_req = 1'b0;
    if (!got) check_eq("host_rd_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_sample(input logic [7:0] v);
    logic got;
    got            = 1'b0;
    s_sample_valid = 1'b1;
    s_sample_data  = v;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = acc_now;
    end
    s_sample_valid = 1'b0;
    if (!got) check_eq("sample_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_busy_low(output int n);
    n = 0;
    for (int i = 0; i < 700; i++) begin
      if (!clear_busy) break;
      n++;
      tick();
    end
    if (clear_busy) check_eq("clear_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_clear(output int n);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_busy_low(n);
  endtask

  task automatic idle_cycles(input int n);
    s_sample_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < 256; i++) check_eq(tag, mem[i], exp_mem[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          n, bad, k, acks, between, lat, pre;
    logic [31:0] want;

    areset = 1'b1; clear_req = 1'b0; s_sample_valid = 1'b0; s_sample_data = '0;
    host_rd_req = 1'b0; host_rd_addr = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    @(negedge aclk);

    // ---- reset with RAM filled with garbage ----
    for (int a = 0; a < 256; a++) begin
      bd_we = 1'b1; bd_addr = 8'(a); bd_data = $urandom;
      exp_mem[a] = bd_data;
      tick();
    end
    bd_we = 1'b0;
    #1;
    check_eq("rst_clear_busy", 32'(clear_busy), 32'd0);
    check_eq("rst_ram_en", 32'(ram_en), 32'd0);
    check_eq("rst_ready", 32'(s_sample_ready), 32'd0);
    check_eq("rst_ack", 32'(host_rd_ack), 32'd0);
    check_eq("rst_rd_data", host_rd_data, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    tick();

    // ---- clear sweep ----
    wr_q.delete();
    do_clear(n);
    check_eq("clr_busy_len_ok", 32'(n >= 256 && n <= 257), 32'd1);
    check_eq("clr_write_count", 32'(wr_q.size()), 32'd256);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i].a != 8'(i) || wr_q[i].d != 0) bad++;
    check_eq("clr_sweep_order", 32'(bad), 32'd0);
    host_read(8'h00, rd); check_eq("clr_rd_00", rd, 32'd0);
    host_read(8'h1C, rd); check_eq("clr_rd_1c", rd, 32'd0);
    host_read(8'hFF, rd); check_eq("clr_rd_ff", rd, 32'd0);

    // ---- directed binning boundaries ----
    send_sample(8'd0); send_sample(8'd32); send_sample(8'd33);
    send_sample(8'd255); send_sample(8'd255);
    idle_cycles(6);
    host_read(8'h00, rd); check_eq("bin_rd_00", rd, 32'd2);
    host_read(8'h04, rd); check_eq("bin_rd_04", rd, 32'd1);
    host_read(8'h1C, rd); check_eq("bin_rd_1c", rd, 32'd2);

    // ---- saturation ----
    bd_we = 1'b1; bd_addr = 8'h08; bd_data = 32'hFFFF_FFFF; exp_mem[8] = 32'hFFFF_FFFF;
    tick();
    bd_we = 1'b0;
    send_sample(8'd70);
    idle_cycles(6);
    host_read(8'h08, rd); check_eq("sat_rd_08", rd, 32'hFFFF_FFFF);

    // ---- round-robin with both requesters continuously present ----
    acks = 0; between = 0; lat = 0;
    s_sample_valid = 1'b1;
    host_rd_req = 1'b1; host_rd_addr = 8'($urandom_range(0, 255));
    for (int c = 0; c < 800 && acks < 30; c++) begin
      s_sample_data = 8'($urandom);
      tick();
      if (acc_now) between++;
      if (host_rd_req) lat++;
      if (ack_now) begin
        acks++;
        if (acks > 1) begin
          check_eq("rr_samples_between_acks", 32'(between), 32'd1);
          check_eq("rr_ack_latency_ok", 32'(lat - 1 <= RMW_MAX + 2), 32'd1);
        end
        between = 0; lat = 0; host_rd_req = 1'b0;
      end else if (!host_rd_req) begin
        host_rd_req = 1'b1; host_rd_addr = 8'($urandom_range(0, 255));
      end
    end
    host_rd_req = 1'b0;
    check_eq("rr_ack_count", 32'(acks), 32'd30);
    idle_cycles(8);

    // ---- random sample traffic ----
    for (int c = 0; c < 400; c++) begin
      s_sample_valid = ($urandom_range(0, 3) != 0);
      s_sample_data  = 8'($urandom);
      tick();
    end
    idle_cycles(8);
    compare_mem("rand_mem_vs_model");

    // ---- 17 samples into one bin (log region behaviour) ----
    do_clear(n);
    repeat (17) send_sample(8'd100);
    idle_cycles(8);
    host_read(8'h0C, rd); check_eq("log_cnt_0c", rd, 32'd17);
`ifdef HIST_VALUE_LOG_EN
    host_read(8'h50, rd); check_eq("log_rd_50", rd, 32'd100);
    host_read(8'h5F, rd); check_eq("log_rd_5f", rd, 32'd100);
`else
    host_read(8'h50, rd); check_eq("log_rd_50", rd, 32'd0);
    host_read(8'h5F, rd); check_eq("log_rd_5f", rd, 32'd0);
`endif
    host_read(8'h60, rd); check_eq("log_rd_60", rd, 32'd0);
    compare_mem("log_mem_vs_model");

    // ---- clear arriving mid-RMW: counter write lands before the sweep ----
    want = exp_mem[24] + 32'd1;
`ifdef HIST_VALUE_LOG_EN
    pre = (exp_mem[24] < 32'd16) ? 2 : 1;
`else
    pre = 1;
`endif
    wr_q.delete();
    send_sample(8'd200);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_busy_low(n);
    check_eq("mid_rmw_first_addr", 32'(wr_q[0].a), 32'h18);
    check_eq("mid_rmw_first_data", wr_q[0].d, want);
    check_eq("mid_rmw_sweep_start", 32'(wr_q[pre].a), 32'd0);
    check_eq("mid_rmw_write_count", 32'(wr_q.size()), 32'(pre + 256));
    host_read(8'h18, rd); check_eq("mid_rmw_rd_18", rd, 32'd0);

    // ---- clear re-requested inside the sweep restarts it ----
    wr_q.delete();
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    repeat (100) tick();
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    k = wr_q.size();
    wait_busy_low(n);
    check_eq("restart_prefix_addr", 32'(wr_q[k-1].a), 32'(k - 1));
    check_eq("restart_addr0", 32'(wr_q[k].a), 32'd0);
    check_eq("restart_write_count", 32'(wr_q.size()), 32'(k + 256));

    // ---- reset in the middle of a sweep ----
    send_sample(8'd5);
    idle_cycles(6);
    host_read(8'h00, rd); check_eq("pre_rst_rd_00", rd, 32'd1);
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    repeat (50) tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    #1;
    check_eq("mrst_clear_busy", 32'(clear_busy), 32'd0);
    check_eq("mrst_ram_en", 32'(ram_en), 32'd0);
    check_eq("mrst_ram_we", 32'(ram_we), 32'd0);
    check_eq("mrst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("mrst_ram_wdata", ram_wdata, 32'd0);
    check_eq("mrst_ready", 32'(s_sample_ready), 32'd0);
    check_eq("mrst_ack", 32'(host_rd_ack), 32'd0);
    check_eq("mrst_rd_data", host_rd_data, 32'd0);
    @(negedge aclk);
    repeat (3) tick();
    check_eq("mrst_no_resume", 32'(ram_en), 32'd0);
    do_clear(n);
    compare_mem("final_mem_vs_model");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
